// File: rtl/moore_seq_arbiter_pkg.sv
// moore_seq_pkg: shared states, widths and symbol extraction for the Moore sequence arbiter
package moore_seq_pkg;
  typedef enum logic [2:0] {IDLE, RST, RUN, CAP, DONE} state_t;
  localparam int SYMW = 2;
  localparam int LENW = 4;
  localparam int SEQ_MAX = (1 << LENW) * SYMW;
  function automatic logic [SYMW-1:0] sym_at(input logic [SEQ_MAX-1:0] s, input logic [LENW-1:0] k);
    return s[k*SYMW +: SYMW];
  endfunction
endpackage

// File: rtl/moore_seq_arbiter_if.sv
// moore_seq_arbiter_if: requester-side bus plus the FSM drive/sense signals of the arbiter
interface moore_seq_arbiter_if #(parameter int NREQ = 2, parameter int MAXLEN = 8, parameter int SYMW = 2);
  import moore_seq_pkg::LENW;
  logic [NREQ-1:0] req;
  logic [NREQ*MAXLEN*SYMW-1:0] seq;
  logic [NREQ*LENW-1:0] len;
  logic [NREQ-1:0] ack;
  logic [SYMW-1:0] result;
  logic [1:0] result_id;
  logic done;
  logic busy;
  logic fsm_reset;
  logic [SYMW-1:0] fsm_in;
  logic [SYMW-1:0] fsm_out;
  modport master(output req, seq, len, fsm_out, input ack, result, result_id, done, busy, fsm_reset, fsm_in);
  modport slave(input req, seq, len, fsm_out, output ack, result, result_id, done, busy, fsm_reset, fsm_in);
endinterface

// File: rtl/moore_seq_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant with a pointer that advances past the served requester
module rr_arbiter #(parameter int NREQ = 2) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  input  logic [1:0]      upd_id,
  output logic [1:0]      gnt_id,
  output logic            gnt_any
);
  logic [1:0] ptr_q, ptr_d, off;
  logic [NREQ-1:0] rot;
  logic [2:0] sum;
  // rotate so bit 0 is the requester at the pointer, then take the lowest set offset
  assign rot = NREQ'({req, req} >> ptr_q);
  always_comb begin
    off = '0;
    gnt_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) begin
      off = 2'(i);
      gnt_any = 1'b1;
    end
  end
  assign sum = {1'b0, ptr_q} + {1'b0, off};
  assign gnt_id = 2'(sum >= 3'(NREQ) ? sum - 3'(NREQ) : sum);
  assign ptr_d = !upd ? ptr_q : int'(upd_id) == NREQ - 1 ? 2'd0 : upd_id + 2'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/moore_seq_arbiter.sv
// moore_seq_arbiter: round-robin sharing of one Moore FSM; resets it, streams a latched
// symbol sequence into it, captures the final output and acks the served requester
module moore_seq_arbiter #(parameter int NREQ = 2, parameter int MAXLEN = 8, parameter int SYMW = 2) (
  input logic clk,
  input logic reset,
  moore_seq_arbiter_if.slave bus
);
  import moore_seq_pkg::state_t, moore_seq_pkg::IDLE, moore_seq_pkg::RST, moore_seq_pkg::RUN;
  import moore_seq_pkg::CAP, moore_seq_pkg::DONE, moore_seq_pkg::LENW, moore_seq_pkg::SEQ_MAX, moore_seq_pkg::sym_at;
  localparam int SW = MAXLEN * SYMW;
  state_t state_q, state_d;
  logic [SW-1:0] seq_q, seq_d, seq_in;
  logic [LENW-1:0] len_q, len_d, cnt_q, cnt_d, len_in;
  logic [1:0] id_q, id_d, gnt_id;
  logic [SYMW-1:0] fsm_in_q, fsm_in_d, result_q, result_d;
  logic gnt_any, last;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk(clk), .reset(reset), .req(bus.req), .upd(state_q == DONE), .upd_id(id_q),
    .gnt_id(gnt_id), .gnt_any(gnt_any)
  );
  assign seq_in = bus.seq[gnt_id*SW +: SW];
  assign len_in = bus.len[gnt_id*LENW +: LENW];
  assign last = cnt_q == len_q - LENW'(1);
  always_comb begin
    state_d = state_q;
    seq_d = seq_q;
    len_d = len_q;
    id_d = id_q;
    cnt_d = cnt_q;
    fsm_in_d = '0;
    result_d = result_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        state_d = RST;
        seq_d = seq_in;
        len_d = len_in > LENW'(MAXLEN) ? LENW'(MAXLEN) : len_in;
        id_d = gnt_id;
      end
      RST: begin
        state_d = len_q == '0 ? CAP : RUN;
        fsm_in_d = len_q == '0 ? '0 : sym_at(SEQ_MAX'(seq_q), '0);
        cnt_d = '0;
      end
      RUN: begin
        state_d = last ? CAP : RUN;
        fsm_in_d = last ? '0 : sym_at(SEQ_MAX'(seq_q), cnt_q + LENW'(1));
        cnt_d = cnt_q + LENW'(1);
      end
      CAP: begin
        state_d = DONE;
        result_d = bus.fsm_out;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      seq_q <= '0;
      len_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      fsm_in_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      len_q <= len_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      fsm_in_q <= fsm_in_d;
      result_q <= result_d;
    end
  end
  // FSM reset follows our own reset combinationally so it never runs while we are held
  assign bus.fsm_reset = reset | (state_q == RST);
  assign bus.fsm_in = fsm_in_q;
  assign bus.done = state_q == DONE;
  assign bus.ack = bus.done ? NREQ'(1) << id_q : '0;
  assign bus.busy = state_q != IDLE;
  assign bus.result = result_q;
  assign bus.result_id = id_q;
endmodule

// File: tb/tb_moore_seq_arbiter.sv
// tb_moore_seq_arbiter: directed scoreboard bench with a small accumulating Moore FSM stand-in
module tb_moore_seq_arbiter;
  typedef struct {int id; logic [1:0] res; logic [15:0] syms; int n;} exp_t;
  localparam logic [15:0] SEQ_A = 16'h0035;
  localparam logic [15:0] SEQ_B = 16'h004E;
  localparam logic [15:0] SEQ_C = 16'hD879;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] fst;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, cyc = 0, rst_cyc = 0, nsym = 0;
  logic [1:0] slog[16];
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  moore_seq_arbiter_if #(.NREQ(2), .MAXLEN(8), .SYMW(2)) bus();
  moore_seq_arbiter #(.NREQ(2), .MAXLEN(8), .SYMW(2)) dut(.clk(clk), .reset(reset), .bus(bus));

  // stand-in FSM: reset state 1, next = state + in, out = state
  always @(posedge clk) fst <= bus.fsm_reset ? 2'd1 : fst + bus.fsm_in;
  assign bus.fsm_out = fst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_txn(input int id, input logic [1:0] res, input logic [15:0] syms, input int n);
    sb.push_back('{id, res, syms, n});
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.done && t < 60);
    n_chk++;
    if (!bus.done) begin
      n_fail++;
      $display("FAIL done_timeout: got no done, required done within 60 cycles");
    end
    bus.req = bus.req & ~bus.ack;
  endtask

  task automatic wait_rst();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.fsm_reset && t < 20);
    n_chk++;
    if (!bus.fsm_reset) begin
      n_fail++;
      $display("FAIL grant_timeout: got no fsm_reset, required one within 20 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(bus.ack), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_result"}, 32'(bus.result), 0);
    chk({tag, "_result_id"}, 32'(bus.result_id), 0);
    chk({tag, "_fsm_in"}, 32'(bus.fsm_in), 0);
    chk({tag, "_fsm_reset"}, 32'(bus.fsm_reset), 1);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("ack_vs_done", 32'(|bus.ack), 32'(bus.done));
      if (prev_done) chk("idle_after_done", 32'(bus.busy), 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got ack=0x%0h id=%0d, required no completion", bus.ack, bus.result_id);
        end else begin
          e = sb.pop_front();
          chk("result_id", 32'(bus.result_id), 32'(e.id));
          chk("result", 32'(bus.result), 32'(e.res));
          chk("ack", 32'(bus.ack), 32'(1) << e.id);
          chk("latency", 32'(cyc - rst_cyc), 32'(e.n + 2));
          for (int k = 0; k < e.n; k++) chk("symbol", 32'(slog[k]), 32'(e.syms[2*k +: 2]));
        end
      end
      if (bus.fsm_reset) begin
        rst_cyc = cyc;
        nsym = 0;
      end else if (nsym < 16) begin
        slog[nsym] = bus.fsm_in;
        nsym++;
      end
      prev_done = bus.done;
    end
  end

  initial begin
    bus.req = '0;
    bus.seq = {SEQ_B, SEQ_A};
    bus.len = {4'd4, 4'd3};
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    // contention from reset: two rounds of both requesting give 0,1,0,1
    for (int r = 0; r < 2; r++) begin
      expect_txn(0, 2'd2, SEQ_A, 3);
      expect_txn(1, 2'd3, SEQ_B, 4);
      bus.req = 2'b11;
      wait_done();
      wait_done();
    end
    expect_txn(0, 2'd2, SEQ_A, 3);
    bus.req = 2'b01;
    wait_done();
    // pointer now at 1, so simultaneous requests serve 1 first
    expect_txn(1, 2'd3, SEQ_B, 4);
    expect_txn(0, 2'd2, SEQ_A, 3);
    bus.req = 2'b11;
    wait_done();
    wait_done();
    bus.len = {4'd4, 4'd0};
    expect_txn(0, 2'd1, 16'h0000, 0);
    bus.req = 2'b01;
    wait_done();
    bus.seq = {SEQ_C, SEQ_A};
    bus.len = {4'd12, 4'd3};
    expect_txn(1, 2'd2, SEQ_C, 8);
    bus.req = 2'b10;
    wait_done();
    bus.seq = {SEQ_B, SEQ_A};
    bus.len = {4'd4, 4'd3};
    expect_txn(1, 2'd3, SEQ_B, 4);
    bus.req = 2'b10;
    wait_rst();
    @(negedge clk);
    bus.req = 2'b00;
    bus.seq = {SEQ_C, SEQ_A};
    wait_done();
    expect_txn(0, 2'd2, SEQ_A, 3);
    bus.req = 2'b01;
    wait_done();
    bus.req = 2'b10;
    wait_rst();
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.seq = {SEQ_B, SEQ_A};
    expect_txn(0, 2'd2, SEQ_A, 3);
    expect_txn(1, 2'd3, SEQ_B, 4);
    bus.req = 2'b11;
    wait_done();
    wait_done();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
